load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 25 ++
 rtl/load_store_unit.sv | 94 +++++++++
 tb/tb_load_store_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory signals of the load/store unit
interface load_store_unit_if #(parameter int ADDR_W = 7);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic              mem_we2;
  logic [31:0]       mem_read_data;
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_write_data, mem_we2
  );
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_write_data, mem_we2
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word loads and read-modify-write stores to word memory; LSU_MISALIGN_TRAP_EN enables misalignment traps
module load_store_unit #(
  parameter int ADDR_W = 7
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
  state_t            state_q, state_d;
  logic              we_q, signed_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, rdata_q, rdata_d, merge_q, merge_d;
  logic [31:0]       shifted, ext, mask, sdata;
  logic [4:0]        sh_amt;
  logic              is_word, is_half, accept, rsp_load, mis_q;
  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign is_word = size_q[1];
  assign is_half = (size_q == 2'b01);
  // low address bits that a wider access cannot use are cleared at capture
  assign addr_d = bus.req_size[1] ? {bus.req_addr[ADDR_W+1:2], 2'b00} :
                  bus.req_size[0] ? {bus.req_addr[ADDR_W+1:1], 1'b0} : bus.req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_d, err_q;
  assign mis_d = bus.req_size[1] ? |bus.req_addr[1:0] : bus.req_size[0] & bus.req_addr[0];
  // flag a misaligned request at accept and publish it with the response
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) mis_q <= mis_d;
      if (rsp_load) err_q <= mis_q;
    end
  assign bus.rsp_err = err_q;
`else
  assign mis_q       = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  // next state: sub-word stores take the extra merge cycle
  always_comb
    state_d = (state_q == IDLE)   ? (bus.req_valid ? ACCESS : IDLE) :
              (state_q == ACCESS) ? ((mis_q || !we_q || is_word) ? RESP : MERGE) :
              (state_q == MERGE)  ? RESP : IDLE;
  // outputs decoded from registered state only, so the write strobe cannot glitch
  always_comb begin
    bus.req_ready      = (state_q == IDLE);
    bus.rsp_valid      = (state_q == RESP);
    bus.mem_we2        = (state_q == MERGE) || ((state_q == ACCESS) && we_q && is_word && !mis_q);
    bus.mem_address    = (state_q == IDLE) ? '0 : addr_q[ADDR_W+1:2];
    bus.mem_write_data = (state_q == MERGE) ? merge_q : wdata_q;
  end
  // lane extraction, extension and lane merge share one shift amount
  always_comb begin
    sh_amt  = {addr_q[1:0], 3'b000};
    shifted = bus.mem_read_data >> sh_amt;
    ext     = is_word ? bus.mem_read_data :
              is_half ? {{16{signed_q & shifted[15]}}, shifted[15:0]} :
                        {{24{signed_q & shifted[7]}}, shifted[7:0]};
    mask    = is_half ? (32'h0000_FFFF << sh_amt) : (32'h0000_00FF << sh_amt);
    sdata   = is_half ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    merge_d = (bus.mem_read_data & ~mask) | (sdata & mask);
    rdata_d = (we_q || mis_q) ? 32'h0 : ext;
  end
  // response data changes only on the edge that enters RESP
  assign rsp_load = ((state_q == ACCESS) && (state_d == RESP)) || (state_q == MERGE);
  // request capture, merge word and response data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we;
        signed_q <= bus.req_signed;
        size_q   <= bus.req_size;
        addr_q   <= addr_d;
        wdata_q  <= bus.req_wdata;
      end
      if (state_q == ACCESS) merge_q <= merge_d;
      if (rsp_load) rdata_q <= rdata_d;
    end
  assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a word-memory model for load_store_unit
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] mem [128];
  int nvec = 0, nerr = 0;
  int wr_cnt = 0, rsp_cnt = 0, acc_cnt = 0, lat;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  load_store_unit_if #(.ADDR_W(7)) bus ();
  load_store_unit #(.ADDR_W(7)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.mem_read_data = mem[bus.mem_address];
  always @(posedge clk) begin
    if (bus.mem_we2) begin
      wr_cnt++;
      wr_addr = bus.mem_address;
      wr_data = bus.mem_write_data;
      mem[bus.mem_address] = bus.mem_write_data;
    end
    if (bus.rsp_valid) rsp_cnt++;
    if (bus.req_valid && bus.req_ready) acc_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [8:0] a, input logic [31:0] wd, output int l);
    @(negedge clk);
    wr_cnt = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!bus.rsp_valid && l < 10);
  endtask
  task automatic load(input string tag, input logic [1:0] sz, input logic sg,
                      input logic [8:0] a, input logic [31:0] exp);
    xact(1'b0, sz, sg, a, 32'h0, lat);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_data"}, bus.rsp_rdata, exp);
    check({tag, "_nowr"}, wr_cnt, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_err", bus.rsp_err, 0);
    check("rst_we", bus.mem_we2, 0);
    check("rst_addr", bus.mem_address, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    // word store then word load
    xact(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, lat);
    check("sw_lat", lat, 2);
    check("sw_wrcnt", wr_cnt, 1);
    check("sw_wraddr", wr_addr, 4);
    check("sw_wrdata", wr_data, 32'hDEADBEEF);
    check("sw_rdata", bus.rsp_rdata, 0);
    @(negedge clk);
    check("sw_pulse", bus.rsp_valid, 0);
    check("sw_ready", bus.req_ready, 1);
    load("lw", 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
    // byte store read-modify-write
    mem[4] = 32'h11223344;
    xact(1'b1, 2'b00, 1'b0, 9'h012, 32'h000000AA, lat);
    check("sb_lat", lat, 3);
    check("sb_wrcnt", wr_cnt, 1);
    check("sb_wrdata", wr_data, 32'h11AA3344);
    check("sb_rdata", bus.rsp_rdata, 0);
    // halfword store to upper lane
    mem[4] = 32'h11223344;
    xact(1'b1, 2'b01, 1'b0, 9'h012, 32'h1234BEEF, lat);
    check("sh_lat", lat, 3);
    check("sh_wrdata", wr_data, 32'hBEEF3344);
    // loads with extension
    mem[4] = 32'h80FF7F01;
    load("lb_s2", 2'b00, 1'b1, 9'h012, 32'hFFFFFFFF);
    load("lbu_3", 2'b00, 1'b0, 9'h013, 32'h00000080);
    load("lb_s3", 2'b00, 1'b1, 9'h013, 32'hFFFFFF80);
    load("lb_s0", 2'b00, 1'b1, 9'h010, 32'h00000001);
    load("lh_s0", 2'b01, 1'b1, 9'h010, 32'h00007F01);
    load("lh_s2", 2'b01, 1'b1, 9'h012, 32'hFFFF80FF);
    load("lhu_2", 2'b01, 1'b0, 9'h012, 32'h000080FF);
    load("lw_rsv", 2'b11, 1'b1, 9'h010, 32'h80FF7F01);
    // highest word address
    xact(1'b1, 2'b10, 1'b0, 9'h1FC, 32'h12345678, lat);
    check("top_wraddr", wr_addr, 127);
    load("top_lw", 2'b10, 1'b0, 9'h1FC, 32'h12345678);
    // misaligned requests
    mem[4] = 32'h80FF7F01;
    xact(1'b0, 2'b10, 1'b0, 9'h011, 32'h0, lat);
    check("mis_lat", lat, 2);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err", bus.rsp_err, 1);
    check("mis_rdata", bus.rsp_rdata, 0);
`else
    check("mis_err", bus.rsp_err, 0);
    check("mis_rdata", bus.rsp_rdata, 32'h80FF7F01);
`endif
    xact(1'b1, 2'b10, 1'b0, 9'h012, 32'hCAFEF00D, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_sw_wr", wr_cnt, 0);
    check("mis_sw_mem", mem[4], 32'h80FF7F01);
    check("mis_sw_err", bus.rsp_err, 1);
`else
    check("mis_sw_wr", wr_cnt, 1);
    check("mis_sw_mem", mem[4], 32'hCAFEF00D);
    check("mis_sw_err", bus.rsp_err, 0);
`endif
    // reset during MERGE of a halfword store
    mem[5] = 32'h55667788;
    @(negedge clk);
    wr_cnt = 0;
    rsp_cnt = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01;
    bus.req_signed = 1'b0; bus.req_addr = 9'h014; bus.req_wdata = 32'h0000CAFE;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 check("abort_merge_we", bus.mem_we2, 1);
    reset = 1'b1;
    #1 check("abort_we_drop", bus.mem_we2, 0);
    check("abort_addr", bus.mem_address, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", bus.req_ready, 1);
    repeat (3) @(negedge clk);
    check("abort_mem", mem[5], 32'h55667788);
    check("abort_wrcnt", wr_cnt, 0);
    check("abort_rsp", rsp_cnt, 0);
    // back-to-back loads with req_valid held high
    mem[4] = 32'h0BADCAFE;
    acc_cnt = 0;
    rsp_cnt = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_addr = 9'h010;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.req_ready) check("b2b_overlap", 1, 0);
    end
    bus.req_valid = 1'b0;
    check("b2b_acc", acc_cnt, 4);
    check("b2b_rsp", rsp_cnt, 4);
    check("b2b_data", bus.rsp_rdata, 32'h0BADCAFE);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
